// File: rtl/digest_collector.sv
// Collects NWORDS answer words from the hash core into one digest, then holds it
// until the consumer acknowledges. Words arriving while a digest is held are dropped.
module digest_collector #(
  parameter  int NWORDS = 10,
  parameter  int WW     = 16,
  localparam int DW     = NWORDS * WW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [WW-1:0] i_word,
  input  logic [DW-1:0] i_expect,
  input  logic          i_ack,
  output logic [DW-1:0] o_digest,
  output logic          o_digest_valid,
  output logic          o_match,
  output logic          o_err_short,
  output logic          o_overrun,
  output logic          o_busy
);

  // state   | meaning
  // IDLE    | no frame in progress, nothing held
  // COLLECT | words 0..count-1 of a frame are in the shadow
  // HOLD    | digest held, waiting for i_ack
  // DROP    | digest held (or just acked) while a word burst is being dropped
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD, S_DROP} state_t;

  localparam int              CW   = $clog2(NWORDS + 1);
  localparam int              SW   = DW - WW;
  localparam logic [CW-1:0]   LAST = CW'(NWORDS - 1);

  state_t        r_state, w_next;
  logic [CW-1:0] r_count, w_count;
  logic [SW-1:0] r_shadow, w_shadow;
  logic [DW-1:0] r_digest, w_digest;
  logic          r_dv, w_dv;
  logic          r_match, w_match;
  logic          r_err, w_err;
  logic          r_ovr, w_ovr;
  logic          w_wr_en;
  logic [CW-1:0] w_wr_idx;
  logic          w_last;
  logic [DW-1:0] w_assembled;

  // The last word never lands in the shadow; it is merged straight into the digest.
  assign w_last      = (r_count == LAST);
  assign w_assembled = {r_shadow, i_word};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_shadow <= '0;
      r_digest <= '0;
      r_dv     <= 1'b0;
      r_match  <= 1'b0;
      r_err    <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_count  <= w_count;
      r_shadow <= w_shadow;
      r_digest <= w_digest;
      r_dv     <= w_dv;
      r_match  <= w_match;
      r_err    <= w_err;
      r_ovr    <= w_ovr;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_valid) w_next = S_COLLECT;
      S_COLLECT: begin
        if (!i_valid)    w_next = S_IDLE;
        else if (w_last) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (i_valid)    w_next = i_ack ? S_COLLECT : S_DROP;
        else if (i_ack) w_next = S_IDLE;
      end
      S_DROP:    if (!i_valid) w_next = (r_dv && !i_ack) ? S_HOLD : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_count  = r_count;
    w_shadow = r_shadow;
    w_digest = r_digest;
    w_dv     = r_dv;
    w_match  = r_match;
    w_err    = 1'b0;
    w_ovr    = 1'b0;
    w_wr_en  = 1'b0;
    w_wr_idx = '0;
    case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          w_wr_en = 1'b1;
          w_count = CW'(1);
        end
      end
      S_COLLECT: begin
        if (!i_valid) begin
          w_err   = 1'b1;
          w_count = '0;
        end else if (w_last) begin
          w_digest = w_assembled;
          w_dv     = 1'b1;
          w_match  = (w_assembled == i_expect);
          w_count  = '0;
        end else begin
          w_wr_en  = 1'b1;
          w_wr_idx = r_count;
          w_count  = r_count + CW'(1);
        end
      end
      S_HOLD: begin
        if (i_ack) begin
          w_dv    = 1'b0;
          w_match = 1'b0;
          if (i_valid) begin
            w_wr_en = 1'b1;
            w_count = CW'(1);
          end
        end else if (i_valid) begin
          w_ovr = 1'b1;
        end
      end
      S_DROP: begin
        w_ovr = i_valid;
        if (i_ack) begin
          w_dv    = 1'b0;
          w_match = 1'b0;
        end
      end
      default: ;
    endcase
    if (w_wr_en) begin
      for (int k = 0; k < NWORDS - 1; k++) begin
        if (w_wr_idx == CW'(k)) w_shadow[SW-1-k*WW -: WW] = i_word;
      end
    end
  end

  assign o_digest       = r_digest;
  assign o_digest_valid = r_dv;
  assign o_match        = r_match;
  assign o_err_short    = r_err;
  assign o_overrun      = r_ovr;
  assign o_busy         = (r_state == S_COLLECT);

endmodule

// File: tb/tb_digest_collector.sv
// Directed scenarios for the digest collector plus a randomized run against a
// queue-based frame model.
module tb_digest_collector;
  localparam int NW = 10;
  localparam int WW = 16;
  localparam int DW = NW * WW;

  localparam logic [DW-1:0] F1 = 160'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A;
  localparam logic [DW-1:0] F2 = 160'h1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic [WW-1:0] i_word;
  logic [DW-1:0] i_expect;
  logic          i_ack;
  logic [DW-1:0] o_digest;
  logic          o_digest_valid, o_match, o_err_short, o_overrun, o_busy;

  int passed = 0;
  int total  = 0;

  digest_collector #(.NWORDS(NW), .WW(WW)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_word(i_word),
    .i_expect(i_expect), .i_ack(i_ack), .o_digest(o_digest),
    .o_digest_valid(o_digest_valid), .o_match(o_match),
    .o_err_short(o_err_short), .o_overrun(o_overrun), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // {digest_valid, match, err_short, overrun, busy}
  function automatic logic [4:0] flags();
    return {o_digest_valid, o_match, o_err_short, o_overrun, o_busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0;
    i_ack   = 1'b0;
    i_word  = '0;
  endtask

  function automatic logic [WW-1:0] word_of(input logic [DW-1:0] f, input int k);
    return f[DW-1-k*WW -: WW];
  endfunction

  task automatic test_reset();
    idle_inputs();
    i_expect = '0;
    rst_n    = 1'b0;
    #2;
    total++;
    if (flags() !== 5'b00000) $display("FAIL reset_flags: got %b want 00000", flags());
    else passed++;
    total++;
    if (o_digest !== '0) $display("FAIL reset_digest: got %h want 0", o_digest);
    else passed++;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_match();
    i_expect = F1;
    for (int k = 0; k < NW; k++) begin
      i_valid = 1'b1;
      i_word  = word_of(F1, k);
      tick();
      if (k == NW - 2) begin
        total++;
        if (flags() !== 5'b00001) $display("FAIL match_latency: got %b want 00001", flags());
        else passed++;
      end
    end
    idle_inputs();
    total++;
    if (flags() !== 5'b11000) $display("FAIL match_flags: got %b want 11000", flags());
    else passed++;
    total++;
    if (o_digest !== F1) $display("FAIL match_digest: got %h want %h", o_digest, F1);
    else passed++;
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    total++;
    if (flags() !== 5'b00000) $display("FAIL match_ack: got %b want 00000", flags());
    else passed++;
  endtask

  task automatic test_mismatch();
    i_expect = F1 ^ 160'd1;
    for (int k = 0; k < NW; k++) begin
      i_valid = 1'b1;
      i_word  = word_of(F1, k);
      tick();
    end
    idle_inputs();
    total++;
    if (flags() !== 5'b10000) $display("FAIL mismatch_flags: got %b want 10000", flags());
    else passed++;
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    total++;
    if (flags() !== 5'b00000) $display("FAIL mismatch_ack: got %b want 00000", flags());
    else passed++;
    total++;
    if (o_digest !== F1) $display("FAIL mismatch_digest_kept: got %h want %h", o_digest, F1);
    else passed++;
  endtask

  task automatic test_short_frame();
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1;
      i_word  = 16'h0050 + 16'(k);
      i_ack   = (k == 2);  // ack while collecting is ignored
      tick();
    end
    idle_inputs();
    tick();
    total++;
    if (flags() !== 5'b00100) $display("FAIL short_pulse: got %b want 00100", flags());
    else passed++;
    tick();
    total++;
    if (flags() !== 5'b00000) $display("FAIL short_single: got %b want 00000", flags());
    else passed++;
    total++;
    if (o_digest !== F1) $display("FAIL short_digest_kept: got %h want %h", o_digest, F1);
    else passed++;
    i_expect = F2;
    for (int k = 0; k < NW; k++) begin
      i_valid = 1'b1;
      i_word  = word_of(F2, k);
      tick();
    end
    idle_inputs();
    total++;
    if (flags() !== 5'b11000 || o_digest !== F2)
      $display("FAIL short_recover: got %b/%h want 11000/%h", flags(), o_digest, F2);
    else passed++;
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
  endtask

  task automatic test_overrun();
    int n_ovr = 0;
    i_expect = F1;
    for (int k = 0; k < NW; k++) begin
      i_valid = 1'b1;
      i_word  = word_of(F1, k);
      tick();
    end
    for (int k = 0; k < NW; k++) begin
      i_valid = 1'b1;
      i_word  = word_of(F2, k);
      tick();
      if (o_overrun === 1'b1) n_ovr++;
      total++;
      if (flags() !== 5'b11010 || o_digest !== F1)
        $display("FAIL overrun_cycle%0d: got %b/%h want 11010/%h", k, flags(), o_digest, F1);
      else passed++;
    end
    idle_inputs();
    tick();
    total++;
    if (n_ovr != NW) $display("FAIL overrun_count: got %0d want %0d", n_ovr, NW);
    else passed++;
    total++;
    if (flags() !== 5'b11000) $display("FAIL overrun_hold: got %b want 11000", flags());
    else passed++;
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    tick();
    tick();
    total++;
    if (flags() !== 5'b00000 || o_digest !== F1)
      $display("FAIL overrun_release: got %b/%h want 00000/%h", flags(), o_digest, F1);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit saw_ovr = 1'b0;
    i_expect = F1;
    for (int k = 0; k < NW; k++) begin
      i_valid = 1'b1;
      i_word  = word_of(F1, k);
      tick();
    end
    i_expect = F2;
    for (int k = 0; k < NW; k++) begin
      i_valid = 1'b1;
      i_ack   = (k == 0);
      i_word  = word_of(F2, k);
      tick();
      if (o_overrun === 1'b1) saw_ovr = 1'b1;
      if (k == 0) begin
        total++;
        if (flags() !== 5'b00001) $display("FAIL b2b_ack_edge: got %b want 00001", flags());
        else passed++;
      end
    end
    idle_inputs();
    total++;
    if (flags() !== 5'b11000 || o_digest !== F2 || saw_ovr)
      $display("FAIL b2b_digest: got %b/%h ovr=%0b want 11000/%h ovr=0", flags(), o_digest, saw_ovr, F2);
    else passed++;
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
  endtask

  task automatic test_reset_midframe();
    for (int k = 0; k < 6; k++) begin
      i_valid = 1'b1;
      i_word  = word_of(F1, k);
      tick();
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (flags() !== 5'b00000 || o_digest !== '0)
      $display("FAIL midreset_async: got %b/%h want 00000/0", flags(), o_digest);
    else passed++;
    i_valid = 1'b1;
    i_word  = 16'hFFFF;
    tick();
    total++;
    if (flags() !== 5'b00000) $display("FAIL midreset_no_accept: got %b want 00000", flags());
    else passed++;
    idle_inputs();
    rst_n = 1'b1;
    tick();
    i_expect = F1;
    for (int k = 0; k < NW; k++) begin
      i_valid = 1'b1;
      i_word  = word_of(F1, k);
      tick();
    end
    idle_inputs();
    total++;
    if (flags() !== 5'b11000 || o_digest !== F1)
      $display("FAIL midreset_recover: got %b/%h want 11000/%h", flags(), o_digest, F1);
    else passed++;
  endtask

  // Reference model: a partial frame is a queue of words; a held digest is a flag
  // plus value; a drop burst lasts while words keep arriving against a held digest.
  logic [WW-1:0] m_q[$];
  logic [DW-1:0] m_digest;
  bit            m_held, m_match, m_burst, m_err, m_ovr;

  function automatic logic [DW-1:0] fold_words(input logic [WW-1:0] q[$]);
    logic [DW-1:0] acc = '0;
    foreach (q[i]) acc = (acc << WW) | DW'(q[i]);
    return acc;
  endfunction

  task automatic model_step(input bit v, input bit a, input logic [WW-1:0] w, input logic [DW-1:0] e);
    m_err = 1'b0;
    m_ovr = 1'b0;
    if (m_burst) begin
      if (a) begin m_held = 1'b0; m_match = 1'b0; end
      if (v) m_ovr = 1'b1;
      else   m_burst = 1'b0;
    end else if (m_held) begin
      if (a) begin
        m_held = 1'b0;
        m_match = 1'b0;
        if (v) m_q.push_back(w);
      end else if (v) begin
        m_ovr   = 1'b1;
        m_burst = 1'b1;
      end
    end else if (v) begin
      m_q.push_back(w);
      if (m_q.size() == NW) begin
        m_digest = fold_words(m_q);
        m_held   = 1'b1;
        m_match  = (m_digest == e);
        m_q.delete();
      end
    end else if (m_q.size() > 0) begin
      m_err = 1'b1;
      m_q.delete();
    end
  endtask

  task automatic test_random();
    logic [4:0] exp_flags;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_q.delete();
    m_digest = '0;
    m_held = 0; m_match = 0; m_burst = 0; m_err = 0; m_ovr = 0;
    tick();
    for (int c = 0; c < 3000; c++) begin
      i_valid = ($urandom_range(0, 99) < 90);
      i_ack   = ($urandom_range(0, 99) < 12);
      i_word  = 16'($urandom);
      if (m_q.size() == NW - 1 && $urandom_range(0, 1) == 1)
        i_expect = (fold_words(m_q) << WW) | DW'(i_word);
      else
        i_expect = {5{32'($urandom)}};
      tick();
      model_step(i_valid, i_ack, i_word, i_expect);
      exp_flags = {m_held, m_match, m_err, m_ovr, (m_q.size() > 0)};
      total++;
      if (flags() !== exp_flags)
        $display("FAIL random_flags c=%0d: got %b want %b", c, flags(), exp_flags);
      else passed++;
      total++;
      if (o_digest !== m_digest)
        $display("FAIL random_digest c=%0d: got %h want %h", c, o_digest, m_digest);
      else passed++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_full_match();
    test_mismatch();
    test_short_frame();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/digest_collector.md
DIGEST_COLLECTOR -- requirements
Module: digest_collector

Interface
REQ-001 Parameter NWORDS, default 10, number of 16-bit words per digest frame.
REQ-002 Parameter WW, default 16, word width in bits; digest width DW = NWORDS*WW (160 by default).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_valid  input  1  word strobe from the hash core answer stream (o_valid/o_answer side).
REQ-006 i_word  input  WW  digest word; first word of a frame is the most significant.
REQ-007 i_expect  input  DW  reference digest, sampled on the frame-completion edge.
REQ-008 i_ack  input  1  consumer acknowledge; releases a held digest.
REQ-009 o_digest  output  DW  assembled digest, held stable while o_digest_valid=1.
REQ-010 o_digest_valid  output  1  level; high from completion until acknowledged.
REQ-011 o_match  output  1  o_digest equals i_expect; meaningful only while o_digest_valid=1.
REQ-012 o_err_short  output  1  one-cycle pulse; frame aborted by a gap in i_valid.
REQ-013 o_overrun  output  1  one-cycle pulse per word dropped while a digest is held.
REQ-014 o_busy  output  1  high while a frame is partially collected (state COLLECT).

Function
REQ-015 The FSM SHALL have four states: IDLE, COLLECT, HOLD, DROP; all outputs registered.
REQ-016 IDLE: i_valid=1 SHALL write i_word to shadow slot 0 (bits DW-1:DW-WW), set count=1, go to COLLECT.
REQ-017 COLLECT: i_valid=1 SHALL write i_word to slot count (bits DW-1-count*WW downto DW-(count+1)*WW) and increment count.
REQ-018 COLLECT: on accepting word NWORDS-1, the same edge SHALL load o_digest from the shadow plus the current word, set o_digest_valid=1, set o_match=(assembled==i_expect), clear count, go to HOLD.
REQ-019 Latency: o_digest_valid SHALL be high in the cycle after the edge that samples the last word; a frame of NWORDS back-to-back words completes in exactly NWORDS cycles.
REQ-020 COLLECT: i_valid=0 SHALL pulse o_err_short for one cycle, discard the partial frame, clear count, go to IDLE; o_digest is unchanged.
REQ-021 HOLD: i_ack=1 with i_valid=0 SHALL clear o_digest_valid and o_match and go to IDLE; o_digest keeps its last value.
REQ-022 HOLD: i_ack=1 with i_valid=1 SHALL clear o_digest_valid and accept i_word as slot 0 of a new frame (count=1, COLLECT).
REQ-023 HOLD: i_valid=1 with i_ack=0 SHALL drop the word, pulse o_overrun, go to DROP.
REQ-024 DROP: each cycle with i_valid=1 SHALL drop the word and pulse o_overrun; o_digest/o_digest_valid stay held until i_ack.
REQ-025 DROP: i_ack=1 SHALL clear o_digest_valid and o_match; the state SHALL leave DROP only on a cycle with i_valid=0, going to HOLD if o_digest_valid is still set after that edge, else IDLE.
REQ-026 i_ack in IDLE or COLLECT SHALL be ignored.
REQ-027 o_busy SHALL equal (state==COLLECT); o_err_short and o_overrun SHALL never be high for two cycles from one event.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, count=0, shadow=0, o_digest=0, o_digest_valid=0, o_match=0, o_err_short=0, o_overrun=0, o_busy=0.
REQ-029 rst_n asserted mid-frame SHALL discard the partial frame; the first i_valid after release starts slot 0.
REQ-030 Reset release SHALL be usable on any edge; no words are accepted in the cycle rst_n is low.

Verification
REQ-031 Words 0x0001..0x000A on 10 consecutive cycles, i_expect=160'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A -> o_digest equals that value, o_digest_valid=1 and o_match=1 one cycle after word 10.
REQ-032 Same frame with i_expect bit 0 flipped -> o_digest_valid=1, o_match=0; i_ack -> o_digest_valid=0 next cycle, o_digest unchanged.
REQ-033 Five words then i_valid=0 -> o_err_short pulses exactly one cycle, o_busy falls, o_digest_valid stays 0; a following full frame completes normally.
REQ-034 Digest held, second 10-word frame sent without i_ack -> o_overrun pulses 10 cycles, o_digest unchanged; i_ack afterwards -> IDLE, no spurious frame.
REQ-035 Digest held, i_ack coincident with word 0 of a new frame 0x1111..0xAAAA -> new digest 160'h1111_2222_..._AAAA after 10 cycles, no overrun.
REQ-036 rst_n pulsed low after word 6 -> all outputs 0 asynchronously; next full frame produces correct digest.
